// File: rtl/alu_arbiter.sv
// Purpose: round-robin arbiter/sequencer sharing one external combinational ALU between two requesters.
// Latency: accept edge N -> alu_* valid from N+1 -> result captured end of N+1 -> resp_valid from N+2.
// Backpressure: one operation in flight; req_ready low in EXEC/RESP, and RESP holds until the owner's resp_ready.
//
// Ports:
//   clk, rst_n                   clock, synchronous active-low reset
//   req_*_0 / req_*_1            request handshake plus operands, signed mode and function code
//   resp_*_0 / resp_*_1          result handshake, data and illegal-function flag (owner only)
//   alu_a/alu_b/alu_signed/alu_func  registered ALU inputs; alu_s is the ALU result
module alu_arbiter #(
    parameter int WIDTH  = 32,
    parameter int FUNC_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid_0,
    input  logic              req_valid_1,
    output logic              req_ready_0,
    output logic              req_ready_1,
    input  logic [WIDTH-1:0]  req_a_0,
    input  logic [WIDTH-1:0]  req_a_1,
    input  logic [WIDTH-1:0]  req_b_0,
    input  logic [WIDTH-1:0]  req_b_1,
    input  logic              req_signed_0,
    input  logic              req_signed_1,
    input  logic [FUNC_W-1:0] req_func_0,
    input  logic [FUNC_W-1:0] req_func_1,
    output logic              resp_valid_0,
    output logic              resp_valid_1,
    input  logic              resp_ready_0,
    input  logic              resp_ready_1,
    output logic [WIDTH-1:0]  resp_data_0,
    output logic [WIDTH-1:0]  resp_data_1,
    output logic              resp_err_0,
    output logic              resp_err_1,
    output logic [WIDTH-1:0]  alu_a,
    output logic [WIDTH-1:0]  alu_b,
    output logic              alu_signed,
    output logic [FUNC_W-1:0] alu_func,
    input  logic [WIDTH-1:0]  alu_s
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]        state_q, state_d;
    logic              owner_q, owner_d;
    logic              last_grant_q, last_grant_d;
    logic [WIDTH-1:0]  alu_a_q, alu_a_d;
    logic [WIDTH-1:0]  alu_b_q, alu_b_d;
    logic              alu_signed_q, alu_signed_d;
    logic [FUNC_W-1:0] alu_func_q, alu_func_d;
    logic [WIDTH-1:0]  result_q, result_d;
    logic              err_q, err_d;

    logic func_legal;
    logic gnt_0, gnt_1;
    logic owner_rdy;

    // Only the function codes the ALU actually implements are accepted.
    always_comb begin
        case (alu_func_q)
            6'b000000, 6'b000001, 6'b011000, 6'b011110,
            6'b010110, 6'b010001, 6'b011010, 6'b100000,
            6'b100001, 6'b100011, 6'b110011, 6'b110001,
            6'b110101, 6'b111101, 6'b111001, 6'b111111: func_legal = 1'b1;
            default:                                    func_legal = 1'b0;
        endcase
    end

    // On a tie the port that did not win last time is granted; last_grant
    // resets to 1 so port 0 wins the first tie.
    assign gnt_0 = req_valid_0 & (~req_valid_1 | last_grant_q);
    assign gnt_1 = req_valid_1 & (~req_valid_0 | ~last_grant_q);

    assign req_ready_0 = (state_q == IDLE) & gnt_0;
    assign req_ready_1 = (state_q == IDLE) & gnt_1;

    assign owner_rdy = owner_q ? resp_ready_1 : resp_ready_0;

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_signed_d = alu_signed_q;
        alu_func_d   = alu_func_q;
        result_d     = result_q;
        err_d        = err_q;
        case (state_q)
            IDLE: begin
                if (req_ready_0 | req_ready_1) begin
                    owner_d      = req_ready_1;
                    alu_a_d      = req_ready_1 ? req_a_1      : req_a_0;
                    alu_b_d      = req_ready_1 ? req_b_1      : req_b_0;
                    alu_signed_d = req_ready_1 ? req_signed_1 : req_signed_0;
                    alu_func_d   = req_ready_1 ? req_func_1   : req_func_0;
                    state_d      = EXEC;
                end
            end
            EXEC: begin
                err_d    = ~func_legal;
                result_d = func_legal ? alu_s : '0;
                state_d  = RESP;
            end
            RESP: begin
                if (owner_rdy) begin
                    last_grant_d = owner_q;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_signed_q <= 1'b0;
            alu_func_q   <= '0;
            result_q     <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_signed_q <= alu_signed_d;
            alu_func_q   <= alu_func_d;
            result_q     <= result_d;
            err_q        <= err_d;
        end
    end

    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_signed = alu_signed_q;
    assign alu_func   = alu_func_q;

    // Response outputs are zero for the non-owner and outside RESP.
    assign resp_valid_0 = (state_q == RESP) & ~owner_q;
    assign resp_valid_1 = (state_q == RESP) &  owner_q;
    assign resp_data_0  = resp_valid_0 ? result_q : '0;
    assign resp_data_1  = resp_valid_1 ? result_q : '0;
    assign resp_err_0   = resp_valid_0 & err_q;
    assign resp_err_1   = resp_valid_1 & err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100001;
    localparam logic [5:0] F_AND = 6'b011000;
    localparam logic [5:0] F_SLL = 6'b000000;
    localparam logic [5:0] F_LT  = 6'b110101;
    localparam logic [5:0] F_BAD = 6'b101010;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid_0, req_valid_1, req_ready_0, req_ready_1;
    logic [31:0] req_a_0, req_a_1, req_b_0, req_b_1;
    logic        req_signed_0, req_signed_1;
    logic [5:0]  req_func_0, req_func_1;
    logic        resp_valid_0, resp_valid_1, resp_ready_0, resp_ready_1;
    logic [31:0] resp_data_0, resp_data_1;
    logic        resp_err_0, resp_err_1;
    logic [31:0] alu_a, alu_b, alu_s;
    logic        alu_signed;
    logic [5:0]  alu_func;

    alu_arbiter #(.WIDTH(32), .FUNC_W(6)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_0(req_valid_0), .req_valid_1(req_valid_1),
        .req_ready_0(req_ready_0), .req_ready_1(req_ready_1),
        .req_a_0(req_a_0), .req_a_1(req_a_1), .req_b_0(req_b_0), .req_b_1(req_b_1),
        .req_signed_0(req_signed_0), .req_signed_1(req_signed_1),
        .req_func_0(req_func_0), .req_func_1(req_func_1),
        .resp_valid_0(resp_valid_0), .resp_valid_1(resp_valid_1),
        .resp_ready_0(resp_ready_0), .resp_ready_1(resp_ready_1),
        .resp_data_0(resp_data_0), .resp_data_1(resp_data_1),
        .resp_err_0(resp_err_0), .resp_err_1(resp_err_1),
        .alu_a(alu_a), .alu_b(alu_b), .alu_signed(alu_signed), .alu_func(alu_func),
        .alu_s(alu_s)
    );

    always #5 clk = ~clk;

    // Reference ALU sitting beside the arbiter; unknown codes give a
    // non-zero pattern so forcing of illegal results to 0 is visible.
    always_comb begin
        case (alu_func)
            F_ADD:   alu_s = alu_a + alu_b;
            F_SUB:   alu_s = alu_a - alu_b;
            F_AND:   alu_s = alu_a & alu_b;
            F_SLL:   alu_s = alu_b << alu_a[4:0];
            F_LT:    alu_s = alu_signed ? {31'd0, $signed(alu_a) < $signed(alu_b)}
                                        : {31'd0, alu_a < alu_b};
            default: alu_s = 32'hDEADBEEF;
        endcase
    end

    typedef struct {
        bit          p;
        logic [31:0] d;
        logic        e;
        int          acc;
        int          first;
    } exp_t;

    exp_t        sq[$];
    bit          gq[$];
    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    int          acc_cnt = 0;
    logic [31:0] ed0, ed1;
    logic        ee0, ee1;

    task automatic chk(string name, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    // One clock: scoreboard observation at the falling edge, then advance
    // to just after the rising edge where the stimulus is changed.
    task automatic cycle();
        exp_t t;
        bit   p;
        @(negedge clk);
        if (rst_n) begin
            chk("ready_exclusive", {31'd0, req_ready_0 & req_ready_1}, 32'd0);
            if (req_valid_0 && req_ready_0) begin
                t.p = 1'b0; t.d = ed0; t.e = ee0; t.acc = cyc; t.first = -1;
                sq.push_back(t); gq.push_back(1'b0); acc_cnt++;
            end
            if (req_valid_1 && req_ready_1) begin
                t.p = 1'b1; t.d = ed1; t.e = ee1; t.acc = cyc; t.first = -1;
                sq.push_back(t); gq.push_back(1'b1); acc_cnt++;
            end
            if (resp_valid_0 || resp_valid_1) begin
                chk("resp_expected", {31'd0, sq.size() != 0}, 32'd1);
                if (sq.size() != 0) begin
                    p = resp_valid_1;
                    chk("resp_port", {31'd0, p}, {31'd0, sq[0].p});
                    chk("resp_data", p ? resp_data_1 : resp_data_0, sq[0].d);
                    chk("resp_err", {31'd0, p ? resp_err_1 : resp_err_0}, {31'd0, sq[0].e});
                    chk("other_valid", {31'd0, p ? resp_valid_0 : resp_valid_1}, 32'd0);
                    chk("other_data", p ? resp_data_0 : resp_data_1, 32'd0);
                    if (sq[0].first < 0) begin
                        sq[0].first = cyc;
                        chk("resp_latency", cyc - sq[0].acc, 32'd2);
                    end
                    if (p ? resp_ready_1 : resp_ready_0) void'(sq.pop_front());
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drive(bit p, logic [31:0] a, logic [31:0] b, logic s,
                         logic [5:0] f, logic [31:0] d, logic e);
        if (p) begin
            req_a_1 = a; req_b_1 = b; req_signed_1 = s; req_func_1 = f;
            ed1 = d; ee1 = e; req_valid_1 = 1'b1;
        end else begin
            req_a_0 = a; req_b_0 = b; req_signed_0 = s; req_func_0 = f;
            ed0 = d; ee0 = e; req_valid_0 = 1'b1;
        end
    endtask

    task automatic wait_accepts(int n, int bound);
        int target = acc_cnt + n;
        int k = 0;
        while (acc_cnt < target && k < bound) begin
            cycle();
            k++;
        end
        chk("accept_in_time", {31'd0, acc_cnt >= target}, 32'd1);
    endtask

    task automatic drain(int bound);
        int k = 0;
        while (sq.size() != 0 && k < bound) begin
            cycle();
            k++;
        end
        chk("drained", sq.size(), 32'd0);
    endtask

    task automatic single(bit p, logic [31:0] a, logic [31:0] b, logic s,
                          logic [5:0] f, logic [31:0] d, logic e);
        drive(p, a, b, s, f, d, e);
        wait_accepts(1, 10);
        req_valid_0 = 1'b0;
        req_valid_1 = 1'b0;
        // Now in EXEC: the ALU sees the latched request.
        chk("alu_a", alu_a, a);
        chk("alu_b", alu_b, b);
        chk("alu_signed", {31'd0, alu_signed}, {31'd0, s});
        chk("alu_func", {26'd0, alu_func}, {26'd0, f});
        drain(10);
    endtask

    task automatic chk_reset_outputs(string tag);
        chk({tag, "_alu_a"}, alu_a, 32'd0);
        chk({tag, "_alu_b"}, alu_b, 32'd0);
        chk({tag, "_alu_signed"}, {31'd0, alu_signed}, 32'd0);
        chk({tag, "_alu_func"}, {26'd0, alu_func}, 32'd0);
        chk({tag, "_resp_valid"}, {30'd0, resp_valid_1, resp_valid_0}, 32'd0);
        chk({tag, "_resp_data0"}, resp_data_0, 32'd0);
        chk({tag, "_resp_data1"}, resp_data_1, 32'd0);
        chk({tag, "_resp_err"}, {30'd0, resp_err_1, resp_err_0}, 32'd0);
    endtask

    initial begin
        int k;
        rst_n = 1'b0;
        req_valid_0 = 1'b0; req_valid_1 = 1'b0;
        req_a_0 = '0; req_a_1 = '0; req_b_0 = '0; req_b_1 = '0;
        req_signed_0 = 1'b0; req_signed_1 = 1'b0;
        req_func_0 = '0; req_func_1 = '0;
        resp_ready_0 = 1'b1; resp_ready_1 = 1'b1;
        ed0 = '0; ed1 = '0; ee0 = 1'b0; ee1 = 1'b0;

        // Reset state
        repeat (3) cycle();
        chk_reset_outputs("reset");
        rst_n = 1'b1;

        // Single ADD from port 0: 15 + (-35) = -20
        single(1'b0, 32'd15, 32'hFFFFFFDD, 1'b0, F_ADD, 32'hFFFFFFEC, 1'b0);

        // Port 1 SLL with resp_ready_1 held low; port 0 waits with a request
        resp_ready_1 = 1'b0;
        drive(1'b1, 32'd22, 32'hFFFFFFDD, 1'b0, F_SLL, 32'hF7400000, 1'b0);
        wait_accepts(1, 10);
        req_valid_1 = 1'b0;
        drive(1'b0, 32'd1, 32'd2, 1'b0, F_ADD, 32'd3, 1'b0);
        k = 0;
        while (!resp_valid_1 && k < 10) begin
            cycle();
            k++;
        end
        for (int i = 0; i < 5; i++) begin
            chk("hold_valid1", {31'd0, resp_valid_1}, 32'd1);
            chk("hold_data1", resp_data_1, 32'hF7400000);
            chk("hold_ready", {30'd0, req_ready_1, req_ready_0}, 32'd0);
            cycle();
        end
        resp_ready_1 = 1'b1;
        wait_accepts(1, 10);
        req_valid_0 = 1'b0;
        drain(10);

        // Illegal function code, then a normal request (from port 1)
        single(1'b0, 32'd7, 32'd9, 1'b0, F_BAD, 32'd0, 1'b1);
        single(1'b1, 32'd100, 32'd23, 1'b0, F_ADD, 32'd123, 1'b0);

        // Both ports valid every cycle: grants must alternate 0,1,0,1
        gq.delete();
        drive(1'b0, 32'd15, 32'hFFFFFFDD, 1'b0, F_AND, 32'h0000000D, 1'b0);
        drive(1'b1, 32'hFFFFFFFF, 32'd1, 1'b0, F_SUB, 32'hFFFFFFFE, 1'b0);
        wait_accepts(4, 40);
        req_valid_0 = 1'b0;
        req_valid_1 = 1'b0;
        drain(10);
        chk("grant_count", gq.size(), 32'd4);
        for (int i = 0; i < 4 && i < gq.size(); i++)
            chk("grant_order", {31'd0, gq[i]}, i % 2);

        // Signed LT: -1 < 1 -> 1
        single(1'b0, 32'hFFFFFFFF, 32'd1, 1'b1, F_LT, 32'd1, 1'b0);

        // Reset asserted in EXEC aborts the operation
        drive(1'b0, 32'd5, 32'd6, 1'b0, F_ADD, 32'd11, 1'b0);
        wait_accepts(1, 10);
        req_valid_0 = 1'b0;
        chk("exec_alu_a", alu_a, 32'd5);
        rst_n = 1'b0;
        sq.delete();
        cycle();
        chk_reset_outputs("abort");
        rst_n = 1'b1;
        cycle();
        chk("abort_no_resp", {30'd0, resp_valid_1, resp_valid_0}, 32'd0);

        // First tie after reset goes to port 0
        gq.delete();
        drive(1'b0, 32'd3, 32'd4, 1'b0, F_ADD, 32'd7, 1'b0);
        drive(1'b1, 32'd10, 32'd4, 1'b0, F_SUB, 32'd6, 1'b0);
        wait_accepts(2, 20);
        req_valid_0 = 1'b0;
        req_valid_1 = 1'b0;
        drain(10);
        chk("post_reset_count", gq.size(), 32'd2);
        if (gq.size() >= 2) begin
            chk("post_reset_first", {31'd0, gq[0]}, 32'd0);
            chk("post_reset_second", {31'd0, gq[1]}, 32'd1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
